// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, FSM states, and the flag bundle.
package alu_pkg;

   localparam int unsigned OP_W            = 5;
   localparam int unsigned OP_FIRST_MULDIV = 16;
   localparam int unsigned OP_LAST         = 21;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 5'd0,
      OP_SUB  = 5'd1,
      OP_AND  = 5'd2,
      OP_OR   = 5'd3,
      OP_XOR  = 5'd4,
      OP_NOR  = 5'd5,
      OP_NOT  = 5'd6,
      OP_SLL  = 5'd7,
      OP_SRL  = 5'd8,
      OP_SRA  = 5'd9,
      OP_SLT  = 5'd10,
      OP_SLTU = 5'd11,
      OP_EQ   = 5'd12,
      OP_NE   = 5'd13,
      OP_GE   = 5'd14,
      OP_GEU  = 5'd15,
      OP_MUL  = 5'd16,
      OP_MULH = 5'd17,
      OP_DIV  = 5'd18,
      OP_DIVU = 5'd19,
      OP_REM  = 5'd20,
      OP_REMU = 5'd21
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

   typedef struct packed {
      logic zero;
      logic carry;
      logic overflow;
      logic negative;
      logic illegal;
   } alu_flags_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative radix-2 multiply/divide engine. One shared 2*WIDTH accumulator:
// shift-add for MUL/MULH, restoring division for DIV/DIVU/REM/REMU.
// Operands are reduced to magnitudes on start; sign and special cases are
// applied combinationally on the final accumulator (result_c).
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             busy,
   input  alu_op_e          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result_c
);

   localparam int unsigned W2 = 2 * WIDTH;

   logic [W2-1:0]    acc_q;
   logic [W2-1:0]    acc_step;
   logic [WIDTH-1:0] opnd_q;
   logic [WIDTH-1:0] a_q;
   alu_op_e          op_q;
   logic             is_mul_q;
   logic             neg_q;
   logic             b_zero_q;

   logic             is_signed;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             res_neg;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_rem;
   logic             div_ge;

   logic [W2-1:0]    prod;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;

   // Operand conditioning at start: magnitudes plus the sign of the final result
   always_comb begin
      is_signed = (op != OP_DIVU) && (op != OP_REMU);
      a_neg     = is_signed & a[WIDTH-1];
      b_neg     = is_signed & b[WIDTH-1];
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;
      case (op)
         OP_MUL, OP_MULH, OP_DIV: res_neg = a_neg ^ b_neg;
         OP_REM:                  res_neg = a_neg;
         default:                 res_neg = 1'b0;
      endcase
   end

   // One radix-2 step of either algorithm on the shared accumulator
   always_comb begin
      mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      div_ge  = acc_q[W2-1:WIDTH-1] >= {1'b0, opnd_q};
      div_rem = div_ge ? (acc_q[W2-1:WIDTH-1] - {1'b0, opnd_q}) : acc_q[W2-1:WIDTH-1];
      if (is_mul_q) begin
         acc_step = {mul_sum, acc_q[WIDTH-1:1]};
      end else begin
         acc_step = {WIDTH'(div_rem), acc_q[WIDTH-2:0], div_ge};
      end
   end

   // Operand capture on start, iteration while the controller is busy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         opnd_q   <= '0;
         a_q      <= '0;
         op_q     <= OP_MUL;
         is_mul_q <= 1'b0;
         neg_q    <= 1'b0;
         b_zero_q <= 1'b0;
      end else if (start) begin
         acc_q    <= {{WIDTH{1'b0}}, a_mag};
         opnd_q   <= b_mag;
         a_q      <= a;
         op_q     <= op;
         is_mul_q <= (op == OP_MUL) || (op == OP_MULH);
         neg_q    <= res_neg;
         b_zero_q <= (b == '0);
      end else if (busy) begin
         acc_q <= acc_step;
      end
   end

   // Sign correction and divide-by-zero handling on the finished accumulator
   always_comb begin
      prod = neg_q ? -acc_q : acc_q;
      quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem  = neg_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
      case (op_q)
         OP_MUL:           result_c = prod[WIDTH-1:0];
         OP_MULH:          result_c = prod[W2-1:WIDTH];
         OP_DIV, OP_DIVU:  result_c = b_zero_q ? '1 : quo;
         OP_REM, OP_REMU:  result_c = b_zero_q ? a_q : rem;
         default:          result_c = '0;
      endcase
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: 16 single-cycle ops plus optional iterative mul/div,
// valid/ready on both sides, registered result and ZCVN/illegal flags.
// Build option: define ALU_MULDIV_EN to implement opcodes 16-21; otherwise
// they complete in one cycle as illegal ops.
module alu_mc
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [4:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_carry,
   output logic             out_overflow,
   output logic             out_negative,
   output logic             out_illegal
);

   localparam int unsigned SHW = $clog2(WIDTH);

   state_e           state_q;
   state_e           state_d;
   logic [SHW-1:0]   cnt_q;
   logic [SHW-1:0]   cnt_d;
   logic             valid_q;
   logic             valid_d;
   logic             load_sc;
   logic             load_md;
   logic [WIDTH-1:0] result_q;
   alu_flags_t       flags_q;

   logic             op_illegal;
   logic             op_md;
   logic [SHW-1:0]   shamt;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] sc_result;
   logic             sc_carry;
   logic             sc_ovf;
   logic [WIDTH-1:0] md_result;

   assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);

`ifdef ALU_MULDIV_EN
   logic md_start_c;

   assign op_illegal = in_op > 5'(OP_LAST);
   assign op_md      = !op_illegal && (in_op >= 5'(OP_FIRST_MULDIV));
   assign md_start_c = in_valid && in_ready && op_md;

   alu_muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (md_start_c),
      .busy     (state_q == BUSY),
      .op       (alu_op_e'(in_op)),
      .a        (in_a),
      .b        (in_b),
      .result_c (md_result)
   );
`else
   assign op_illegal = in_op >= 5'(OP_FIRST_MULDIV);
   assign op_md      = 1'b0;
   assign md_result  = '0;
`endif

   assign shamt = in_b[SHW-1:0];

   // Single-cycle datapath, evaluated on the operands being accepted
   always_comb begin
      sum       = '0;
      sc_result = '0;
      sc_carry  = 1'b0;
      sc_ovf    = 1'b0;
      case (alu_op_e'(in_op))
         OP_ADD: begin
            sum       = {1'b0, in_a} + {1'b0, in_b};
            sc_result = sum[WIDTH-1:0];
            sc_carry  = sum[WIDTH];
            sc_ovf    = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
         end
         OP_SUB: begin
            sum       = {1'b0, in_a} - {1'b0, in_b};
            sc_result = sum[WIDTH-1:0];
            sc_carry  = sum[WIDTH];
            sc_ovf    = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
         end
         OP_AND:  sc_result = in_a & in_b;
         OP_OR:   sc_result = in_a | in_b;
         OP_XOR:  sc_result = in_a ^ in_b;
         OP_NOR:  sc_result = ~(in_a | in_b);
         OP_NOT:  sc_result = ~in_a;
         OP_SLL:  sc_result = in_a << shamt;
         OP_SRL:  sc_result = in_a >> shamt;
         OP_SRA:  sc_result = $signed(in_a) >>> shamt;
         OP_SLT:  sc_result = WIDTH'($signed(in_a) < $signed(in_b));
         OP_SLTU: sc_result = WIDTH'(in_a < in_b);
         OP_EQ:   sc_result = WIDTH'(in_a == in_b);
         OP_NE:   sc_result = WIDTH'(in_a != in_b);
         OP_GE:   sc_result = WIDTH'($signed(in_a) >= $signed(in_b));
         OP_GEU:  sc_result = WIDTH'(in_a >= in_b);
         default: sc_result = '0;
      endcase
   end

   // Control FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   // Next state: accept from IDLE or on a DONE handshake, iterate, fix up, present
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      load_sc = 1'b0;
      load_md = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if ((state_q == IDLE) || out_ready) begin
               state_d = IDLE;
               valid_d = 1'b0;
               if (in_valid) begin
                  if (op_md) begin
                     state_d = BUSY;
                     cnt_d   = SHW'(WIDTH - 1);
                  end else begin
                     state_d = DONE;
                     valid_d = 1'b1;
                     load_sc = 1'b1;
                  end
               end
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - SHW'(1);
            end
         end
         FIX: begin
            state_d = DONE;
            valid_d = 1'b1;
            load_md = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output register: loaded once per operation, held through backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         flags_q  <= '0;
      end else if (load_sc) begin
         result_q         <= sc_result;
         flags_q.zero     <= (sc_result == '0);
         flags_q.carry    <= sc_carry;
         flags_q.overflow <= sc_ovf;
         flags_q.negative <= sc_result[WIDTH-1];
         flags_q.illegal  <= op_illegal;
      end else if (load_md) begin
         result_q         <= md_result;
         flags_q.zero     <= (md_result == '0);
         flags_q.carry    <= 1'b0;
         flags_q.overflow <= 1'b0;
         flags_q.negative <= md_result[WIDTH-1];
         flags_q.illegal  <= 1'b0;
      end
   end

   assign out_valid    = valid_q;
   assign out_result   = result_q;
   assign out_zero     = flags_q.zero;
   assign out_carry    = flags_q.carry;
   assign out_overflow = flags_q.overflow;
   assign out_negative = flags_q.negative;
   assign out_illegal  = flags_q.illegal;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multi-cycle, parametrised successor to the team's combinational ALU.
- Accepts one operation per valid/ready handshake and returns a registered result plus ZCVN flags through a second valid/ready handshake.
- Adds iterative multiply/divide to the existing 16 single-cycle ops.
- Sits between the decode/issue stage and writeback of the simple core.

Parameters:
- WIDTH, 32, datapath width in bits; must be ≥ 8 and a power of two.
- SHW, $clog2(WIDTH), shift-amount bits taken from b (derived; not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request valid
- in_ready  output  1  block can accept an operation this cycle
- in_a  input  WIDTH  operand a
- in_b  input  WIDTH  operand b
- in_op  input  5  opcode; values 0–15 keep the existing ALU encoding, 16–21 = MUL, MULH, DIV, DIVU, REM, REMU
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_result  output  WIDTH  result
- out_zero  output  1  result == 0
- out_carry  output  1  carry/borrow; ADD/SUB only, else 0
- out_overflow  output  1  signed overflow; ADD/SUB only, else 0
- out_negative  output  1  result[WIDTH-1]
- out_illegal  output  1  opcode 22–31, or a mul/div op with the feature compiled out

Behaviour:
- Reset: state IDLE, out_valid=0, out_result=0, all flags 0, in_ready=1 on the first cycle after release.
- Reset is asynchronous and clears everything mid-operation; the in-flight op is discarded and no out_valid is produced for it.
- Accept: in_valid & in_ready at a rising edge. Operands and opcode are captured; later input changes are ignored.

State machine:
- IDLE:
  - Single-cycle op (0–15) or illegal op → DONE.
  - Mul/div op → BUSY, iteration counter loaded to WIDTH-1.
- BUSY:
  - One radix-2 iteration per cycle.
  - At counter 0 → FIX, which applies sign correction and special cases → DONE.
- DONE:
  - out_valid=1. Result and flags are held stable until out_valid & out_ready.
  - On handshake: a new accept in the same cycle → next state as from IDLE; otherwise → IDLE.

Handshake and latency:
- in_ready = (state==IDLE) | (state==DONE & out_ready). This gives full throughput for back-to-back single-cycle ops.
- Single-cycle ops: out_valid is asserted on the 1st edge after accept.
- Mul/div: out_valid is asserted on the (WIDTH+2)th edge after accept.
- out_ready is not required while out_valid=0.

Single-cycle op semantics (encoding 0–15):
- ADD, SUB, AND, OR, XOR, NOR, NOT(a), SLL, SRL, SRA, SLT, SLTU, EQ, NE, GE, GEU.
- Shifts use b[SHW-1:0].
- Compares return 1 or 0, zero-extended.
- ADD/SUB use a WIDTH+1-bit sum; carry is bit WIDTH (for SUB this is the borrow).
- Overflow is the classic sign rule.

Mul/div op semantics:
- MUL: low WIDTH bits of the signed×signed product (equal to unsigned low half).
- MULH: high WIDTH bits of the signed×signed product.
- DIV/REM: signed; quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = a. out_illegal=0.
- Signed overflow (a=MIN, b=-1): DIV = MIN, REM = 0.

Flags and illegal ops:
- zero and negative are computed from the final result for every op.
- Illegal op: result 0, zero=1, out_illegal=1, single-cycle latency.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: opcodes 16–21 are implemented as above using the iterative sub-module.
- Undefined: the sub-module is not instantiated, BUSY/FIX are unreachable, and opcodes 16–21 are treated as illegal (1-cycle, result 0, out_illegal=1).

Decomposition:
- Package alu_pkg:
  - alu_op_e enum (5-bit, all 22 opcodes)
  - state enum {IDLE, BUSY, FIX, DONE}
  - localparams OP_FIRST_MULDIV=16, OP_LAST=21
- Sub-module alu_muldiv_iter (WIDTH):
  - start/busy/done interface
  - shift-add multiplier and restoring divider sharing one 2·WIDTH accumulator
  - sign handling and divide-by-zero/overflow special cases
- alu_mc contains the control FSM, the single-cycle datapath and the output register.

Test Plan:
- WIDTH=32, ADD 0xFFFFFFFF+1, out_ready=1 → 1 cycle later result 0, zero=1, carry=1, overflow=0. SUB 0x80000000−1 → 0x7FFFFFFF, overflow=1.
- Ten back-to-back single-cycle ops with in_valid and out_ready held high → in_ready stays 1 and one result per cycle, in order. Drop out_ready for 3 cycles → result and flags held stable, in_ready=0.
- MUL −3×7 → 0xFFFFFFEB. MULH 0x80000000×0x80000000 → 0x40000000. out_valid on the 34th edge after accept; in_ready=0 throughout.
- DIV −7/2 → 0xFFFFFFFD, REM −7%2 → 0xFFFFFFFF; DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/−1 → 0x80000000, REM → 0.
- Assert rst_n=0 at iteration 10 of a DIV → all outputs 0 immediately. After release: in_ready=1, no stale out_valid, and the next ADD completes normally.
- Opcode 25 → 1 cycle later result 0, zero=1, out_illegal=1. Build without ALU_MULDIV_EN, MUL 3×4 → result 0, out_illegal=1, latency 1.
